// File: rtl/sccb_cfg_sequencer.sv
// sccb_cfg_sequencer
//   Post-reset camera register loader. Walks an external {reg,data} table and
//   issues one 3-phase SCCB write (DEV_ADDR, reg, data) per entry on an
//   open-drain SCL/SDA pair. An entry whose reg byte is 8'hFF is a delay
//   marker: it causes DELAY_CYC idle cycles and no bus traffic.
// Ports
//   iCLK     system clock
//   iRST     asynchronous, active-low reset
//   iGO      level enable: high = run / hold result, low = abort and rewind
//   oIDX     table address
//   iDATA    table entry {reg[15:8], data[7:0]}, valid 1 cycle after oIDX
//   oSCL     SCL level (1 = released)
//   oSDA_OE  1 = pull SDA low, 0 = release
//   iSDA     SDA pin readback (ACK slot)
//   oBUSY    sequence in progress
//   oDONE    all entries written (sticky while iGO high)
//   oERR     entry failed after MAX_RETRY retries (sticky while iGO high)
module sccb_cfg_sequencer #(
    parameter int         CLK_DIV     = 125,
    parameter logic [7:0] DEV_ADDR    = 8'h42,
    parameter int         NUM_ENTRIES = 32,
    parameter int         IDX_W       = 8,
    parameter int         DELAY_CYC   = 500000,
    parameter int         MAX_RETRY   = 3
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iGO,
    output logic [IDX_W-1:0] oIDX,
    input  logic [15:0]      iDATA,
    output logic             oSCL,
    output logic             oSDA_OE,
    input  logic             iSDA,
    output logic             oBUSY,
    output logic             oDONE,
    output logic             oERR
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int DLY_W = $clog2(DELAY_CYC + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_DELAY, S_START, S_BYTE, S_STOP, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [3:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RTY_W-1:0] rty_q, rty_d;
    logic             nack_q, nack_d;
    logic             ld_q, ld_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       dat_q, dat_d;

    logic bus_phase;
    logic tick;
    logic advance;

    // The divider only runs in the bus-timed states, so every write starts
    // on a fresh quarter-bit and lasts exactly 120 ticks.
    assign bus_phase = (state_q == S_START) || (state_q == S_BYTE) ||
                       (state_q == S_STOP)  || (state_q == S_GAP);
    assign tick      = bus_phase && (div_q == DIV_LAST);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            dly_q   <= '0;
            idx_q   <= '0;
            rty_q   <= '0;
            nack_q  <= 1'b0;
            ld_q    <= 1'b0;
            reg_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            dly_q   <= dly_d;
            idx_q   <= idx_d;
            rty_q   <= rty_d;
            nack_q  <= nack_d;
            ld_q    <= ld_d;
            reg_q   <= reg_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = '0;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        dly_d   = dly_q;
        idx_d   = idx_q;
        rty_d   = rty_q;
        nack_d  = nack_q;
        ld_d    = ld_q;
        reg_d   = reg_q;
        dat_d   = dat_q;
        advance = 1'b0;

        if (bus_phase) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                rty_d = '0;
                ld_d  = 1'b0;
                if (iGO) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // First cycle covers the table read latency.
                if (!ld_q) begin
                    ld_d = 1'b1;
                end else begin
                    ld_d  = 1'b0;
                    reg_d = iDATA[15:8];
                    dat_d = iDATA[7:0];
                    if (iDATA[15:8] == 8'hFF) begin
                        state_d = S_DELAY;
                        dly_d   = '0;
                    end else begin
                        state_d = S_START;
                        qtr_d   = '0;
                        nack_d  = 1'b0;
                    end
                end
            end
            S_DELAY: begin
                if (dly_q == DLY_LAST) begin
                    advance = 1'b1;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    qtr_d = qtr_q + 1'b1;
                    if (qtr_q == 2'd3) begin
                        state_d = S_BYTE;
                        bit_d   = '0;
                        byte_d  = '0;
                    end
                end
            end
            S_BYTE: begin
                // ACK sampled on the first cycle of q2.
                if (bit_q == 4'd8 && qtr_q == 2'd2 && div_q == '0 && iSDA) begin
                    nack_d = 1'b1;
                end
                if (tick) begin
                    qtr_d = qtr_q + 1'b1;
                    if (qtr_q == 2'd3) begin
                        if (bit_q == 4'd8) begin
                            bit_d = '0;
                            if (nack_q || byte_q == 2'd2) begin
                                state_d = S_STOP;
                            end else begin
                                byte_d = byte_q + 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    qtr_d = qtr_q + 1'b1;
                    if (qtr_q == 2'd3) begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    qtr_d = qtr_q + 1'b1;
                    if (qtr_q == 2'd3) begin
                        if (!nack_q) begin
                            advance = 1'b1;
                        end else if (rty_q == RTY_MAX) begin
                            state_d = S_ERROR;
                        end else begin
                            rty_d   = rty_q + 1'b1;
                            state_d = S_LOAD;
                            ld_d    = 1'b0;
                        end
                    end
                end
            end
            S_DONE, S_ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            rty_d = '0;
            if (idx_q == IDX_LAST) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_LOAD;
                ld_d    = 1'b0;
            end
        end

        // Abort overrides everything; no STOP is generated.
        if (!iGO) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end
    end

    logic [7:0] cur_byte;
    logic [2:0] bidx;

    always_comb begin
        cur_byte = DEV_ADDR;
        if (byte_q == 2'd1) cur_byte = reg_q;
        if (byte_q == 2'd2) cur_byte = dat_q;
        bidx     = 3'(4'd7 - bit_q);

        oSCL    = 1'b1;
        oSDA_OE = 1'b0;
        case (state_q)
            S_START: begin
                oSDA_OE = qtr_q[1];
            end
            S_BYTE: begin
                oSCL    = (qtr_q == 2'd1) || (qtr_q == 2'd2);
                oSDA_OE = (bit_q != 4'd8) && !cur_byte[bidx];
            end
            S_STOP: begin
                oSCL    = (qtr_q != 2'd0);
                oSDA_OE = (qtr_q != 2'd3);
            end
            default: begin
                oSCL    = 1'b1;
                oSDA_OE = 1'b0;
            end
        endcase

        oIDX  = idx_q;
        oDONE = (state_q == S_DONE);
        oERR  = (state_q == S_ERROR);
        oBUSY = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    end

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// tb_sccb_cfg_sequencer
//   Directed bench for sccb_cfg_sequencer with a bus monitor / SCCB slave
//   model and a scoreboard of expected {ack, byte} values.
module tb_sccb_cfg_sequencer;

    localparam int CLK_DIV     = 2;
    localparam int NUM_ENTRIES = 3;
    localparam int DELAY_CYC   = 100;
    localparam int MAX_RETRY   = 1;
    localparam int IDX_W       = 8;

    logic             clk;
    logic             rst_n;
    logic             go;
    logic [IDX_W-1:0] idx;
    logic [15:0]      idata;
    logic             scl;
    logic             sda_oe;
    logic             isda;
    logic             busy;
    logic             done;
    logic             err;

    sccb_cfg_sequencer #(
        .CLK_DIV    (CLK_DIV),
        .DEV_ADDR   (8'h42),
        .NUM_ENTRIES(NUM_ENTRIES),
        .IDX_W      (IDX_W),
        .DELAY_CYC  (DELAY_CYC),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .iCLK   (clk),
        .iRST   (rst_n),
        .iGO    (go),
        .oIDX   (idx),
        .iDATA  (idata),
        .oSCL   (scl),
        .oSDA_OE(sda_oe),
        .iSDA   (isda),
        .oBUSY  (busy),
        .oDONE  (done),
        .oERR   (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Table with one cycle of read latency.
    logic [15:0] tbl [0:255];
    always @(posedge clk) idata <= tbl[idx];

    // Open-drain SDA line.
    logic slave_pull;
    logic sda_line;
    assign sda_line = ~(sda_oe | slave_pull);
    assign isda     = sda_line;

    // Slave NACK control (written by the stimulus only).
    int mon_en     = 0;
    int nack_idx   = 0;
    int nack_byte  = 0;
    int nack_limit = 0;

    // Monitor state (written by the monitor only).
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       m_scl;
    logic       m_sda;
    logic [7:0] shreg;
    logic       ackbit;
    logic [8:0] obs [0:63];
    int obs_n = 0;
    int in_txn = 0;
    int bitcnt = 0;
    int bytecnt = 0;
    int nack_cnt = 0;
    int proto_err = 0;
    int rise_t = 0;
    int scl_edges = 0;
    int last_edge = -1;
    int max_gap = 0;
    int n_start = 0;
    int n_stop = 0;
    int start_t [0:7];
    int stop_t [0:7];

    initial slave_pull = 1'b0;

    always @(negedge clk) begin
        m_scl = scl;
        m_sda = sda_line;
        if (mon_en == 0) begin
            in_txn = 0; bitcnt = 0; bytecnt = 0; obs_n = 0; nack_cnt = 0;
            proto_err = 0; scl_edges = 0; last_edge = -1; max_gap = 0;
            n_start = 0; n_stop = 0; slave_pull = 1'b0;
        end else begin
            if (m_scl != prev_scl) begin
                scl_edges++;
                if (last_edge >= 0 && (cyc - last_edge) > max_gap) max_gap = cyc - last_edge;
                last_edge = cyc;
            end
            if (prev_scl && m_scl && prev_sda && !m_sda) begin
                if (in_txn != 0) proto_err++;
                in_txn = 1; bitcnt = 0; bytecnt = 0;
                if (n_start < 8) start_t[n_start] = cyc;
                n_start++;
            end else if (prev_scl && m_scl && !prev_sda && m_sda) begin
                // A STOP's own SCL rise is counted as one clock.
                if (in_txn == 0 || bitcnt != 1) proto_err++;
                in_txn = 0;
                if (n_stop < 8) stop_t[n_stop] = cyc;
                n_stop++;
            end else if (in_txn != 0 && !prev_scl && m_scl) begin
                rise_t = cyc;
                if (bitcnt < 8) shreg = {shreg[6:0], m_sda};
                else ackbit = m_sda;
                bitcnt++;
            end else if (in_txn != 0 && prev_scl && !m_scl) begin
                if (bitcnt != 0 && (cyc - rise_t) != 2 * CLK_DIV) proto_err++;
                if (bitcnt == 8) begin
                    if (nack_cnt < nack_limit && int'(idx) == nack_idx && bytecnt == nack_byte) begin
                        nack_cnt++;
                        slave_pull = 1'b0;
                    end else begin
                        slave_pull = 1'b1;
                    end
                end else if (bitcnt == 9) begin
                    slave_pull = 1'b0;
                    if (obs_n < 64) obs[obs_n] = {ackbit, shreg};
                    obs_n++;
                    bitcnt = 0;
                    bytecnt++;
                end
            end
        end
        prev_scl = m_scl;
        prev_sda = m_sda;
    end

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q [$];
    int rd = 0;
    int end_cyc = 0;
    int e0 = 0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = budget;
        while (exp_q.size() > 0 && n > 0) begin
            @(negedge clk);
            n--;
            while (rd < obs_n && rd < 64 && exp_q.size() > 0) begin
                chk("bus_byte", 32'(obs[rd]), 32'(exp_q.pop_front()));
                rd++;
            end
        end
        if (exp_q.size() > 0) chk("byte_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = budget;
        do begin
            @(negedge clk);
            n--;
        end while (busy && n > 0);
        end_cyc = cyc;
        if (busy) chk("end_timeout", 32'(busy), 0);
    endtask

    task automatic restart();
        go = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 0;
        exp_q.delete();
        rd = 0;
        repeat (2) @(negedge clk);
        mon_en = 1;
    endtask

    task automatic load_tbl(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        tbl[0] = a;
        tbl[1] = b;
        tbl[2] = c;
    endtask

    task automatic push_t1();
        exp_q.push_back(9'h042); exp_q.push_back(9'h012); exp_q.push_back(9'h080);
        exp_q.push_back(9'h042); exp_q.push_back(9'h011); exp_q.push_back(9'h001);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tbl[i] = 16'h0000;
        rst_n = 1'b0;
        go    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_scl", 32'(scl), 1);
        chk("rst_sda_oe", 32'(sda_oe), 0);
        chk("rst_idx", 32'(idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        restart();

        // T1/T2: two writes around a delay marker
        load_tbl(16'h1280, 16'hFF00, 16'h1101);
        nack_limit = 0;
        push_t1();
        go = 1'b1;
        drain(3000);
        wait_end(2000);
        chk("t1_done", 32'(done), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_err", 32'(err), 0);
        chk("t1_idx", 32'(idx), NUM_ENTRIES - 1);
        chk("t1_extra_bytes", obs_n, rd);
        chk("t2_protocol", proto_err, 0);
        chk("t1_starts", n_start, 2);
        chk("t1_delay_gap", 32'(max_gap >= DELAY_CYC), 1);
        // START SDA fall at tick 2, STOP SDA rise at tick 115.
        chk("t2_start_to_stop", stop_t[0] - start_t[0], (115 - 2) * CLK_DIV);
        // Transaction is 120 ticks; SDA fall is 2 ticks after it starts.
        chk("t2_txn_span", end_cyc - start_t[1], (120 - 2) * CLK_DIV);
        e0 = scl_edges;
        repeat (50) @(negedge clk);
        chk("t1_hold_done", 32'(done), 1);
        chk("t1_hold_no_edges", scl_edges, e0);

        // T3: NACK on data byte of entry 0 once
        restart();
        nack_idx = 0; nack_byte = 2; nack_limit = 1;
        exp_q.push_back(9'h042); exp_q.push_back(9'h012); exp_q.push_back(9'h180);
        push_t1();
        go = 1'b1;
        drain(5000);
        wait_end(2000);
        chk("t3_done", 32'(done), 1);
        chk("t3_err", 32'(err), 0);
        chk("t3_extra_bytes", obs_n, rd);
        chk("t3_protocol", proto_err, 0);

        // T4: entry 1 NACKs the device address every time
        restart();
        load_tbl(16'h1280, 16'h3456, 16'h1101);
        nack_idx = 1; nack_byte = 0; nack_limit = 99;
        exp_q.push_back(9'h042); exp_q.push_back(9'h012); exp_q.push_back(9'h080);
        exp_q.push_back(9'h142); exp_q.push_back(9'h142);
        go = 1'b1;
        drain(5000);
        wait_end(2000);
        chk("t4_err", 32'(err), 1);
        chk("t4_done", 32'(done), 0);
        chk("t4_idx", 32'(idx), 1);
        chk("t4_scl", 32'(scl), 1);
        chk("t4_sda_oe", 32'(sda_oe), 0);
        repeat (300) @(negedge clk);
        chk("t4_no_more_bytes", obs_n, 5);
        chk("t4_err_held", 32'(err), 1);

        // T5: abort in the middle of the reg byte of entry 0
        restart();
        load_tbl(16'h1280, 16'hFF00, 16'h1101);
        nack_limit = 0;
        exp_q.push_back(9'h042);
        go = 1'b1;
        drain(1000);
        repeat (12) @(negedge clk);
        chk("t5_busy_before", 32'(busy), 1);
        go = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_scl", 32'(scl), 1);
        chk("t5_sda_oe", 32'(sda_oe), 0);
        chk("t5_idx", 32'(idx), 0);
        chk("t5_busy", 32'(busy), 0);
        restart();
        push_t1();
        go = 1'b1;
        drain(3000);
        wait_end(2000);
        chk("t5_restart_done", 32'(done), 1);
        chk("t5_protocol", proto_err, 0);

        // T6: asynchronous reset during the delay entry
        restart();
        exp_q.push_back(9'h042); exp_q.push_back(9'h012); exp_q.push_back(9'h080);
        go = 1'b1;
        drain(1000);
        repeat (30) @(negedge clk);
        chk("t6_in_delay_idx", 32'(idx), 1);
        chk("t6_in_delay_busy", 32'(busy), 1);
        e0 = scl_edges;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_scl", 32'(scl), 1);
        chk("t6_sda_oe", 32'(sda_oe), 0);
        chk("t6_idx", 32'(idx), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_err", 32'(err), 0);
        go = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_no_scl_edge", scl_edges, e0);
        chk("t6_idle_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
